// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer driving an external shift_reg: it loads the operand,
// then issues one 1-bit shift per cycle and returns the shift_reg output as the result.
module shift_seq_ctrl #(
    parameter int W     = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic             sr_parallel,
    output logic             sr_right,
    output logic [W-1:0]     sr_data,
    output logic             sr_R,
    output logic             sr_L,
    input  logic [W-1:0]     sr_q,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_q;
    logic [1:0]       op_q;
    logic [W-1:0]     data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            amt_q       <= '0;
            op_q        <= '0;
            data_q      <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            sr_parallel <= 1'b1;
            sr_right    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        op_q     <= in_op;
                        amt_q    <= in_amt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= amt_q;
                    if (amt_q == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sr_parallel <= 1'b0;
                        sr_right    <= (op_q != OP_LSL);
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) begin
                        sr_parallel <= 1'b1;
                        sr_right    <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outside LOAD, feeding sr_q back keeps shift_reg holding (its data is ignored while shifting).
    assign sr_data   = (state == LOAD) ? data_q : sr_q;
    assign out_data  = sr_q;
    assign sr_R      = 1'b0;
    assign dbg_state = state;

    always_comb begin
        sr_L = 1'b0;
        if (state == SHIFT) begin
            case (op_q)
                OP_ASR:  sr_L = sr_q[W-1];
                OP_ROR:  sr_L = sr_q[0];
                default: sr_L = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural shift_reg attached; checks results,
// latency, DONE back-pressure and mid-operation reset.
module tb_shift_seq_ctrl;
    localparam int W     = 4;
    localparam int AMT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [1:0]       in_op = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic             busy;
    logic             sr_parallel;
    logic             sr_right;
    logic [W-1:0]     sr_data;
    logic             sr_R;
    logic             sr_L;
    logic [W-1:0]     sr_q = '0;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    shift_seq_ctrl #(.W(W), .AMT_W(AMT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .sr_parallel(sr_parallel), .sr_right(sr_right), .sr_data(sr_data),
        .sr_R(sr_R), .sr_L(sr_L), .sr_q(sr_q), .dbg_state(dbg_state)
    );

    // ---------------- clock / shift_reg model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_parallel)   sr_q <= sr_data;
        else if (sr_right) sr_q <= {sr_L, sr_q[W-1:1]};
        else               sr_q <= {sr_q[W-2:0], sr_R};
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] op,
                                               input int a);
        logic [2*W-1:0] t;
        case (op)
            2'b00: begin t = {{W{1'b0}}, d} << a; return t[W-1:0]; end
            2'b01: return d >> a;
            2'b10: return W'($signed(d) >>> a);
            default: begin t = {d, d} >> a; return t[W-1:0]; end
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic [W-1:0] d, input logic [1:0] op,
                          input logic [AMT_W-1:0] amt, input int hold);
        int edges;
        int guard;
        logic [W-1:0] held;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
        check("in_ready_before_req", int'(in_ready), 1);
        in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt; out_ready = 1'b0;
        exp_q.push_back(ref_shift(d, op, int'(amt)));
        @(posedge clk);
        #1 in_valid = 1'b0;
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            check("busy_no_ready", int'({busy, in_ready}), 2);
            @(posedge clk); edges++;
            @(negedge clk);
        end
        check("latency", edges, int'(amt) + 2);
        if (exp_q.size() > 0) check("out_data", int'(out_data), int'(exp_q.pop_front()));
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_data = ~d; in_amt = '0;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(held));
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("back_idle", int'({out_valid, in_ready, busy}), 3'b010);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0]     d;
        logic [1:0]       op;
        logic [AMT_W-1:0] amt;
        int               hold;
        logic [W-1:0]     exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'b0011, 2'b00, 2'd2, 0, 4'b1100};
        vecs[1] = '{4'b1000, 2'b10, 2'd3, 0, 4'b1111};
        vecs[2] = '{4'b1000, 2'b01, 2'd3, 0, 4'b0001};
        vecs[3] = '{4'b1001, 2'b11, 2'd1, 0, 4'b1100};
        vecs[4] = '{4'b0110, 2'b11, 2'd3, 0, 4'b1100};
        vecs[5] = '{4'b1010, 2'b00, 2'd0, 0, 4'b1010};
        vecs[6] = '{4'b1011, 2'b01, 2'd1, 5, 4'b0101};

        repeat (3) @(negedge clk);
        check("rst_outs", int'({in_ready, out_valid, busy, sr_parallel, sr_right, sr_L, sr_R}),
              7'b1001000);
        check("rst_state", int'(dbg_state), 0);
        check("rst_sr_hold", int'(sr_data), int'(sr_q));
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            check("table_model", int'(ref_shift(vecs[i].d, vecs[i].op, int'(vecs[i].amt))),
                  int'(vecs[i].exp));
            do_req(vecs[i].d, vecs[i].op, vecs[i].amt, vecs[i].hold);
        end

        for (int i = 0; i < 40; i++) begin
            do_req(W'($urandom), 2'($urandom_range(0, 3)), AMT_W'($urandom_range(0, W - 1)),
                   $urandom_range(0, 3));
        end

        // Reset during SHIFT: LSL 0001 amt 3, after one shift.
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0001; in_op = 2'b00; in_amt = 2'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_state_shift", int'(dbg_state), 2);
        reset = 1'b0;
        #1;
        check("mid_rst_outs", int'({in_ready, out_valid, busy, sr_parallel, sr_right}), 5'b10010);
        check("mid_rst_state", int'(dbg_state), 0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_sr_kept", int'(sr_q), 4'b0010);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("after_rst_no_valid", int'({out_valid, in_ready, busy}), 3'b010);

        do_req(4'b0101, 2'b10, 2'd2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
